// File: rtl/tdm8_receiver.sv
// Receive end of the 8-channel TDM link: rebuilds one 8-slot frame from the serial
// stream and presents it on a parallel bus, with slot index and framing-error pulses.
module tdm8_receiver #(
  parameter int unsigned TIMEOUT    = 16,
  parameter bit          OUT_INVERT = 1'b0
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iBit,
  input  logic       iValid,
  input  logic       iSync,
  output logic [7:0] oData,
  output logic       oFrameValid,
  output logic       oSyncErr,
  output logic       oA,
  output logic       oB,
  output logic       oC
);

  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;
  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_ONE  = TW'(1);
  localparam logic [TW-1:0] GAP_ZERO = TW'(0);
  localparam logic [7:0]    DATA_RST = OUT_INVERT ? 8'hFF : 8'h00;

  logic [0:0]    state_r, state_s;
  logic [2:0]    cnt_r, cnt_s;
  logic [TW-1:0] gap_r, gap_s;
  logic [7:0]    shadow_r, shadow_s;
  logic [7:0]    data_r, data_s;
  logic          fv_r, fv_s;
  logic          err_r, err_s;
  logic [2:0]    sel_r, sel_s;
  logic [7:0]    frame_s;

  // Next-state and next-output decode for the hunt/receive framing machine
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    gap_s    = gap_r;
    shadow_s = shadow_r;
    data_s   = data_r;
    fv_s     = 1'b0;
    err_s    = 1'b0;
    sel_s    = sel_r;
    frame_s  = {iBit, shadow_r[6:0]};
    case (state_r)
      ST_HUNT: begin
        gap_s = GAP_ZERO;
        if (iValid && iSync) begin
          shadow_s[0] = iBit;
          cnt_s       = 3'd1;
          sel_s       = 3'd0;
          state_s     = ST_RECV;
        end else begin
          state_s = ST_HUNT;
        end
      end
      ST_RECV: begin
        if (iValid) begin
          gap_s = GAP_ZERO;
          if (iSync) begin
            // Resync mid-frame: restart at slot 0, oData untouched
            err_s       = 1'b1;
            shadow_s[0] = iBit;
            cnt_s       = 3'd1;
            sel_s       = 3'd0;
          end else begin
            shadow_s[cnt_r] = iBit;
            sel_s           = cnt_r;
            cnt_s           = cnt_r + 3'd1;
            if (cnt_r == 3'd7) begin
              data_s  = OUT_INVERT ? ~frame_s : frame_s;
              fv_s    = 1'b1;
              state_s = ST_HUNT;
            end else begin
              state_s = ST_RECV;
            end
          end
        end else begin
          if (gap_r == GAP_LAST) begin
            err_s   = 1'b1;
            cnt_s   = 3'd0;
            gap_s   = GAP_ZERO;
            state_s = ST_HUNT;
          end else begin
            gap_s = gap_r + GAP_ONE;
          end
        end
      end
      default: begin
        state_s = ST_HUNT;
        cnt_s   = 3'd0;
        gap_s   = GAP_ZERO;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_r  <= ST_HUNT;
      cnt_r    <= 3'd0;
      gap_r    <= GAP_ZERO;
      shadow_r <= 8'h00;
      data_r   <= DATA_RST;
      fv_r     <= 1'b0;
      err_r    <= 1'b0;
      sel_r    <= 3'd0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      gap_r    <= gap_s;
      shadow_r <= shadow_s;
      data_r   <= data_s;
      fv_r     <= fv_s;
      err_r    <= err_s;
      sel_r    <= sel_s;
    end
  end

  assign oData       = data_r;
  assign oFrameValid = fv_r;
  assign oSyncErr    = err_r;
  assign oA          = sel_r[2];
  assign oB          = sel_r[1];
  assign oC          = sel_r[0];

endmodule

// File: tb/tb_tdm8_receiver.sv
// Directed and random checks of tdm8_receiver (plain and inverted builds) against a
// queue-based frame model.
module tb_tdm8_receiver;

  localparam int TIMEOUT = 16;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic       iBit = 1'b0;
  logic       iValid = 1'b0;
  logic       iSync = 1'b0;
  logic [7:0] data, idata;
  logic       fv, err, a, b, c;
  logic       ifv, ierr, ia, ib, ic;

  int errors = 0;
  int checks = 0;

  // model state
  logic       q[$];
  bit         in_frame = 1'b0;
  int         gap = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_fv = 1'b0;
  logic       m_err = 1'b0;
  logic [2:0] m_sel = 3'd0;

  int cyc = 0;
  int err_seen = 0;
  int fv_seen = 0;
  int last_fv_cyc = 0;
  int prev_fv_cyc = 0;

  always #5 iClk = ~iClk;

  tdm8_receiver #(.TIMEOUT(TIMEOUT), .OUT_INVERT(1'b0)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iBit(iBit), .iValid(iValid), .iSync(iSync),
    .oData(data), .oFrameValid(fv), .oSyncErr(err), .oA(a), .oB(b), .oC(c));

  tdm8_receiver #(.TIMEOUT(TIMEOUT), .OUT_INVERT(1'b1)) dut_inv (
    .iClk(iClk), .iRst_n(iRst_n), .iBit(iBit), .iValid(iValid), .iSync(iSync),
    .oData(idata), .oFrameValid(ifv), .oSyncErr(ierr), .oA(ia), .oB(ib), .oC(ic));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("data", {24'd0, data}, {24'd0, m_data});
    chk("data_inv", {24'd0, idata}, {24'd0, ~m_data});
    chk("frame_valid", {31'd0, fv}, {31'd0, m_fv});
    chk("sync_err", {31'd0, err}, {31'd0, m_err});
    chk("slot", {29'd0, a, b, c}, {29'd0, m_sel});
    chk("inv_pulses", {30'd0, ifv, ierr}, {30'd0, m_fv, m_err});
    chk("inv_slot", {29'd0, ia, ib, ic}, {29'd0, m_sel});
  endtask

  task automatic model_reset();
    q.delete();
    in_frame = 1'b0;
    gap = 0;
    m_data = 8'h00;
    m_fv = 1'b0;
    m_err = 1'b0;
    m_sel = 3'd0;
  endtask

  // one clock: drive, advance, update model, compare
  task automatic step(input logic v, input logic s, input logic bt);
    iValid = v;
    iSync = s;
    iBit = bt;
    @(posedge iClk);
    cyc++;
    m_fv = 1'b0;
    m_err = 1'b0;
    if (v) begin
      gap = 0;
      if (s) begin
        if (in_frame) m_err = 1'b1;
        q.delete();
        q.push_back(bt);
        in_frame = 1'b1;
        m_sel = 3'd0;
      end else if (in_frame) begin
        q.push_back(bt);
        m_sel = 3'(q.size() - 1);
        if (q.size() == 8) begin
          for (int i = 0; i < 8; i++) m_data[i] = q[i];
          m_fv = 1'b1;
          in_frame = 1'b0;
          q.delete();
        end
      end
    end else if (in_frame) begin
      gap++;
      if (gap == TIMEOUT) begin
        m_err = 1'b1;
        in_frame = 1'b0;
        q.delete();
        gap = 0;
      end
    end
    #1;
    if (err) err_seen++;
    if (fv) begin
      fv_seen++;
      prev_fv_cyc = last_fv_cyc;
      last_fv_cyc = cyc;
    end
    compare_all();
  endtask

  task automatic send_frame(input logic [7:0] f, input int idle);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, (k == 0), f[k]);
      if (k < 7) for (int g = 0; g < idle; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge iClk);
    #1;
    compare_all();
    chk("reset_data_inv", {24'd0, idata}, 32'h0000_00FF);
    iRst_n = 1'b1;

    // 1: 8'hFE back to back
    send_frame(8'hFE, 0);
    chk("t1_data", {24'd0, data}, 32'h0000_00FE);
    chk("t1_fv", {31'd0, fv}, 32'd1);
    chk("t1_slot", {29'd0, a, b, c}, 32'd7);
    step(1'b0, 1'b0, 1'b0);
    chk("t1_fv_once", {31'd0, fv}, 32'd0);

    // 2: 8'hA5 with 3 idle cycles between bits
    err_seen = 0;
    send_frame(8'hA5, 3);
    chk("t2_data", {24'd0, data}, 32'h0000_00A5);
    chk("t2_no_err", err_seen, 32'd0);

    // 3: resync at slot 4, then 7 more bits
    send_frame(8'hFE, 0);
    step(1'b1, 1'b1, 1'b0);
    for (int k = 1; k < 4; k++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("t3_err", {31'd0, err}, 32'd1);
    chk("t3_hold", {24'd0, data}, 32'h0000_00FE);
    for (int k = 1; k < 7; k++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("t3_data", {24'd0, data}, 32'h0000_007F);

    // 4: timeout after sync + 3 bits, then unsynced bits ignored
    err_seen = 0;
    step(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) step(1'b0, 1'b0, 1'b0);
    chk("t4_no_early_err", err_seen, 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("t4_err", {31'd0, err}, 32'd1);
    fv_seen = 0;
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    chk("t4_ignored", fv_seen, 32'd0);
    chk("t4_hold", {24'd0, data}, 32'h0000_007F);

    // 5: asynchronous reset at slot 5
    step(1'b1, 1'b1, 1'b1);
    for (int k = 1; k < 5; k++) step(1'b1, 1'b0, 1'b0);
    iRst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("t5_data", {24'd0, data}, 32'd0);
    @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    send_frame(8'hFD, 0);
    chk("t5_frame", {24'd0, data}, 32'h0000_00FD);

    // 6: zero-gap frames, inverted bus
    send_frame(8'hFE, 0);
    chk("t6_inv1", {24'd0, idata}, 32'h0000_0001);
    send_frame(8'hFD, 0);
    chk("t6_inv2", {24'd0, idata}, 32'h0000_0002);
    chk("t6_spacing", last_fv_cyc - prev_fv_cyc, 32'd8);

    // random traffic: busy phase then sparse phase to provoke timeouts
    for (int n = 0; n < 600; n++)
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
    for (int n = 0; n < 600; n++)
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
